// File: rtl/btn_trigger_conditioner.sv
// Push-button front end: per-button 2-flop sync and debounce FSM, lowest-index
// press arbitration, global retrigger lockout and last-accepted-button report.
module btn_trigger_conditioner #(
  parameter int NUM_BTNS    = 5,
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LOCKOUT_MS  = 250
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse,
  output logic [2:0]          song_sel,
  output logic                lockout
);

  localparam int DB_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int LK_CYCLES = (CLK_FREQ / 1000) * LOCKOUT_MS;
  localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LK_W      = (LK_CYCLES > 1) ? $clog2(LK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LK_CYCLES - 1);

  if (NUM_BTNS < 1 || NUM_BTNS > 7) begin : g_bad_num_btns
    $error("NUM_BTNS must be in 1..7");
  end
  if (DB_CYCLES < 2) begin : g_bad_debounce
    $error("debounce time must span at least 2 clock cycles");
  end
  if (LK_CYCLES < 1) begin : g_bad_lockout
    $error("lockout time must span at least 1 clock cycle");
  end

  typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} db_state_t;

  logic [NUM_BTNS-1:0] sync_p0;
  logic [NUM_BTNS-1:0] sync_p1;
  logic [NUM_BTNS-1:0] qual;
  logic [NUM_BTNS-1:0] pulse;
  logic [2:0]          pulse_sel;
  logic [LK_W-1:0]     lk_cnt;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: qual is a one-cycle flag raised only on a LOW->HIGH commit
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
    db_state_t       state;
    logic [DB_W-1:0] cnt;
    logic            level_r;
    logic            qual_r;

    always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
        state   <= LOW;
        cnt     <= '0;
        level_r <= 1'b0;
        qual_r  <= 1'b0;
      end else begin
        qual_r <= 1'b0;
        case (state)
          LOW: begin
            if (sync_p1[i]) begin
              state <= WAIT_HI;
              cnt   <= '0;
            end
          end
          WAIT_HI: begin
            if (!sync_p1[i]) begin
              state <= LOW;
            end else if (cnt == DB_LAST) begin
              state   <= HIGH;
              level_r <= 1'b1;
              qual_r  <= 1'b1;
            end else begin
              cnt <= cnt + DB_W'(1);
            end
          end
          HIGH: begin
            if (!sync_p1[i]) begin
              state <= WAIT_LO;
              cnt   <= '0;
            end
          end
          WAIT_LO: begin
            if (sync_p1[i]) begin
              state <= HIGH;
            end else if (cnt == DB_LAST) begin
              state   <= LOW;
              level_r <= 1'b0;
            end else begin
              cnt <= cnt + DB_W'(1);
            end
          end
          default: state <= LOW;
        endcase
      end
    end

    assign btn_level[i] = level_r;
    assign qual[i]      = qual_r;
  end

  // Arbitration: descending scan so the lowest qualifying index overwrites the rest
  always_comb begin
    pulse     = '0;
    pulse_sel = '0;
    if (!lockout) begin
      for (int i = NUM_BTNS - 1; i >= 0; i--) begin
        if (qual[i]) begin
          pulse     = '0;
          pulse[i]  = 1'b1;
          pulse_sel = 3'(i + 1);
        end
      end
    end
  end

  assign btn_pulse = pulse;

  // Lockout stage: counter runs LK_CYCLES-1 down to 0, flag drops on the next edge
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      lockout  <= 1'b0;
      lk_cnt   <= '0;
      song_sel <= '0;
    end else begin
      if (lockout) begin
        if (lk_cnt == '0) begin
          lockout <= 1'b0;
        end else begin
          lk_cnt <= lk_cnt - LK_W'(1);
        end
      end else if (|pulse) begin
        lockout <= 1'b1;
        lk_cnt  <= LK_LAST;
      end
      if (|pulse) begin
        song_sel <= pulse_sel;
      end
    end
  end

endmodule

// File: tb/tb_btn_trigger_conditioner.sv
// Randomized and directed bench for btn_trigger_conditioner with a run-length
// debounce model, a time-window lockout model and a pulse scoreboard.
module tb_btn_trigger_conditioner;

  localparam int NB = 5;
  localparam int DB = 4;
  localparam int LK = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [2:0]    song_sel;
  logic          lockout;

  btn_trigger_conditioner #(
    .NUM_BTNS   (NB),
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4),
    .LOCKOUT_MS (10)
  ) dut (
    .clk_100MHz(clk),
    .reset     (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .song_sel  (song_sel),
    .lockout   (lockout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FSM sees btn_raw two edges late; a button's level
  // flips once DB+1 consecutive samples disagree with it.
  typedef struct {
    int edge_n;
    int idx;
  } exp_t;

  exp_t          sbq[$];
  int            cyc = 0;
  logic [NB-1:0] m_s0 = '0;
  logic [NB-1:0] m_s1 = '0;
  logic [NB-1:0] m_level = '0;
  int            m_run[NB];
  bit            m_acc_valid = 1'b0;
  int            m_last_acc = 0;
  int            m_sel = 0;
  bit            m_pend = 1'b0;
  int            m_pend_sel = 0;
  int            m_pend_edge = 0;

  function automatic bit model_locked();
    return m_acc_valid && (cyc >= m_last_acc + 1) && (cyc <= m_last_acc + LK);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s0 = '0;
      m_s1 = '0;
      m_level = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      m_acc_valid = 1'b0;
      m_sel = 0;
      m_pend = 1'b0;
      sbq.delete();
    end else begin
      logic [NB-1:0] samp;
      logic [NB-1:0] quals;
      int win;
      cyc++;
      samp = m_s1;
      m_s1 = m_s0;
      m_s0 = btn_raw;
      quals = '0;
      for (int i = 0; i < NB; i++) begin
        if (samp[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_level[i] = samp[i];
            m_run[i] = 0;
            if (samp[i]) quals[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (m_pend && cyc == m_pend_edge + 1) begin
        m_sel = m_pend_sel;
        m_pend = 1'b0;
      end
      if (!model_locked() && quals != '0) begin
        win = -1;
        for (int i = NB - 1; i >= 0; i--) if (quals[i]) win = i;
        sbq.push_back('{edge_n: cyc, idx: win});
        m_last_acc = cyc;
        m_acc_valid = 1'b1;
        m_pend = 1'b1;
        m_pend_sel = win + 1;
        m_pend_edge = cyc;
      end
    end
  end

  // Monitor: compares registered outputs each cycle and consumes pulse expectations
  always @(negedge clk) begin
    exp_t e;
    chk("btn_level", int'(btn_level), int'(m_level));
    chk("lockout", int'(lockout), int'(model_locked()));
    chk("song_sel", int'(song_sel), m_sel);
    if (btn_pulse != '0) begin
      n_pulses++;
      if (sbq.size() == 0) begin
        chk("pulse_unexpected", int'(btn_pulse), 0);
      end else begin
        e = sbq.pop_front();
        chk("pulse_vec", int'(btn_pulse), 1 << e.idx);
        chk("pulse_edge", cyc, e.edge_n);
      end
    end else if (sbq.size() > 0 && sbq[0].edge_n <= cyc) begin
      e = sbq.pop_front();
      chk("pulse_missing", 0, 1 << e.idx);
    end
  end

  task automatic hold(input logic [NB-1:0] v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset(input int n);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_level", int'(btn_level), 0);
    chk("rst_pulse", int'(btn_pulse), 0);
    chk("rst_song_sel", int'(song_sel), 0);
    chk("rst_lockout", int'(lockout), 0);
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 2_000_000);
    $fatal(1);
  end

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("init_level", int'(btn_level), 0);
    chk("init_song_sel", int'(song_sel), 0);
    chk("init_lockout", int'(lockout), 0);
    rst = 1'b0;
    hold('0, 5);

    // single press and release
    hold(5'b00010, 30);
    hold(5'b00000, 20);
    // short glitches
    hold(5'b00001, 3);
    hold(5'b00000, 2);
    hold(5'b00001, 3);
    hold(5'b00000, 15);
    // simultaneous qualify
    hold(5'b01100, 30);
    hold(5'b00000, 20);
    // qualify during lockout, then re-press
    hold(5'b00001, 3);
    hold(5'b10001, 25);
    hold(5'b00000, 20);
    hold(5'b10000, 20);
    hold(5'b00000, 20);
    // reset mid-debounce with the button held through release
    hold(5'b00010, 3);
    async_reset(2);
    hold(5'b00010, 20);
    hold(5'b00000, 20);
    // reset mid-lockout
    hold(5'b01000, 10);
    async_reset(2);
    hold(5'b00000, 20);
    // long hold with short dropout
    p0 = n_pulses;
    hold(5'b00100, 500);
    hold(5'b00000, 2);
    hold(5'b00100, 498);
    hold(5'b00000, 20);
    chk("long_hold_pulses", n_pulses - p0, 1);

    for (int k = 0; k < 80; k++) begin
      hold(5'($urandom_range(0, 31)), int'($urandom_range(1, 40)));
      if ($urandom_range(0, 19) == 0) async_reset(1);
    end
    hold('0, 30);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_trigger_conditioner.md
Name: btn_trigger_conditioner

Overview:
Front-end stage that conditions the board push-buttons into clean play triggers for the song-logic players. Each player's FSM leaves idle on a single-cycle high of its w_btnN input, so every raw button is synchronised, debounced and turned into a one-cycle press pulse. The block also applies a global retrigger lockout and reports the index of the last accepted button. Outputs btn_pulse[i] connect directly to w_btn(i+1) of the song modules.

Parameters:
NUM_BTNS, 5, number of buttons handled; legal range 1..7.
CLK_FREQ, 100_000_000, clock frequency in Hz.
DEBOUNCE_MS, 10, stability time in ms. DB_CYCLES = (CLK_FREQ/1000)*DEBOUNCE_MS; must be >= 2.
LOCKOUT_MS, 250, global retrigger lockout in ms. LK_CYCLES = (CLK_FREQ/1000)*LOCKOUT_MS; must be >= 1.

Ports:
clk_100MHz  in   1         system clock
reset       in   1         asynchronous, active-high reset
btn_raw     in   NUM_BTNS  raw, asynchronous button levels (1 = pressed)
btn_level   out  NUM_BTNS  debounced button levels
btn_pulse   out  NUM_BTNS  one-cycle accepted-press pulses, at most one bit high per cycle
song_sel    out  3         (index + 1) of the last accepted button; 0 = none since reset
lockout     out  1         high while the retrigger lockout is running

Behaviour:
- Interface: one clock, clk_100MHz. reset is asynchronous and active-high.
- Reset values: all synchroniser flops 0, every debounce FSM in LOW, counters 0, btn_level 0, btn_pulse 0, song_sel 0, lockout 0. Reset acts immediately and mid-operation, aborting any debounce or lockout in progress.
- Per-button synchroniser: a 2-flop chain produces sync[i]. Only sync[i] feeds the FSM.
- Per-button debounce FSM, with states LOW, WAIT_HI, HIGH and WAIT_LO, and counter cnt[i] sized for DB_CYCLES-1:
  - LOW: if sync=1, go to WAIT_HI with cnt=0.
  - WAIT_HI: if sync=0, return to LOW. Else if cnt==DB_CYCLES-1, go to HIGH, set btn_level=1 and raise the "qualify" flag. Else increment cnt.
  - HIGH: if sync=0, go to WAIT_LO with cnt=0.
  - WAIT_LO: if sync=1, return to HIGH; this is not a new press. Else if cnt==DB_CYCLES-1, go to LOW and set btn_level=0. Else increment cnt.
  - Glitches shorter than DB_CYCLES never change btn_level.
- Latency: count edge 0 as the first clock edge that samples btn_raw=1 on a held press. btn_level and the qualify flag are registered high at edge DB_CYCLES+2. The resulting btn_pulse is driven combinationally from registered state in that same cycle and lasts exactly one cycle.
- Pulse arbitration:
  - A qualify with lockout=0 is accepted and produces btn_pulse[i]=1 for one cycle.
  - If several buttons qualify in the same cycle, the lowest index wins. The others are dropped and are never deferred.
  - A qualify while lockout=1 is dropped, but btn_level still follows the button.
- Lockout:
  - The cycle after an accepted pulse, lockout=1 and the lockout counter loads LK_CYCLES-1.
  - The counter decrements each cycle; lockout clears on the cycle after it reaches 0. Lockout is therefore high for exactly LK_CYCLES cycles.
  - lockout does not restart while already active.
- song_sel: loads i+1 on the same edge that registers an accepted pulse, then holds. It never returns to 0 except on reset.
- A button held through reset release is treated as a new press: it must be stable for DB_CYCLES and then produces a pulse.
- Holding a button never produces more than one pulse.

Test Plan:
(Use CLK_FREQ=1000, DEBOUNCE_MS=4 (DB_CYCLES=4), LOCKOUT_MS=10 (LK_CYCLES=10), NUM_BTNS=5.)
1. Hold btn_raw[1]=1 from edge 0 -> btn_pulse=5'b00010 for exactly one cycle after edge 6; btn_level[1]=1; song_sel=2; lockout high for exactly the next 10 cycles. Release and hold low -> btn_level[1]=0 six cycles later, with no pulse.
2. Pulse btn_raw[0] high for 3 cycles, low 2, high 3 -> btn_level and btn_pulse stay 0 throughout.
3. Raise btn_raw[3] and btn_raw[2] on the same edge and hold -> only btn_pulse[2] fires; song_sel=3; both btn_level bits become 1.
4. Press btn 0 and accept it; press btn 4 so it qualifies during lockout -> no btn_pulse[4] and song_sel stays 1. Re-press btn 4 after lockout clears -> btn_pulse[4] fires and song_sel=5.
5. Assert reset asynchronously mid-WAIT_HI and mid-lockout -> all outputs 0 immediately. Keep btn 1 held through reset release -> one pulse 6 edges after the first post-reset sampling edge.
6. Hold btn 2 for 1000 cycles with a 2-cycle dropout in the middle -> exactly one pulse; btn_level[2] stays 1 across the dropout.
